output_compare: RTL and testbench
=================================

// Module: output_compare
// PURPOSE
//  16-bit timer output-compare channel; transmit-side counterpart of the input-capture unit.
//  Free-running up-counter with programmable period (TOP) and compare value (CMP).
//  Drives a pin (toggle/set/clear/PWM) and a sticky event flag on match.
//  Compare and period registers are double-buffered for glitch-free updates.
// PARAMETERS
//  CMP_RST  16'hFFFF  reset value of CMP buffer and active register
//  TOP_RST  16'hFFFF  reset value of TOP buffer and active register
// PORTS
//  i_sysclk    in   1   system clock, all logic on rising edge
//  i_sysrst    in   1   reset, synchronous, active-low
//  i_cnt_en    in   1   counter enable
//  i_clr       in   1   counter clear
//  i_cmp_wr    in   1   write strobe, i_cmp_data -> CMP buffer
//  i_cmp_data  in   16  compare value
//  i_top_wr    in   1   write strobe, i_top_data -> TOP buffer
//  i_top_data  in   16  period value; counter runs 0..TOP
//  i_mode      in   2   00 toggle, 01 set, 10 clear, 11 PWM
//  i_flg_clr   in   1   clears o_oc_flg and o_ovf_flg
//  o_oc_pin    out  1   compare output pin, registered
//  o_oc_flg    out  1   sticky compare-match flag
//  o_ovf_flg   out  1   sticky wrap (overflow) flag
//  o_cnt_data  out  16  current counter value
// BEHAVIOUR
//  Reset (i_sysrst=0 at edge): cnt=0, pin=0, both flags=0; buffers and active regs = *_RST.
//  Counter priority per edge: i_clr -> cnt=0; else i_cnt_en & cnt==top_act -> cnt=0 (wrap);
//   else i_cnt_en -> cnt+1; else hold. Unsigned 16 bit; TOP=0 wraps every cycle.
//  Update point: wrap edge, OR any edge with i_clr=1, OR any edge with i_cnt_en=0.
//   At an update point: cmp_act<=cmp_buf, top_act<=top_buf (values before that edge's writes).
//   A buffer write landing on an update edge takes effect at the next update point.
//  Match: i_cnt_en=1 & i_clr=0 & cnt==cmp_act in the current cycle. Pin/flag change at that edge,
//   i.e. visible 1 cycle after o_cnt_data shows the match value.
//  CMP>TOP: never matches (modes 00-10).
//  Modes 00/01/10 on match: pin <= ~pin / 1 / 0.
//  Mode 11 PWM: pin <= (cnt_next < cmp_next); cmp_next = value cmp_act takes at this edge.
//   Per period, pin high for CMP cycles out of TOP+1.
//   CMP=0 -> constant 0; CMP>TOP -> constant 1. Evaluated only while i_cnt_en=1; else pin holds.
//  i_mode change applies on the next edge; pin is not reset by a mode change.
//  Disabled (i_cnt_en=0): counter, pin and flags hold (only i_flg_clr acts).
//  o_oc_flg set on match (all modes); o_ovf_flg set on wrap edge; i_clr never sets o_ovf_flg.
//  Set and i_flg_clr in the same cycle: set wins (flag stays 1).
//  Reset mid-run: all state returns to reset values at that edge; pending buffer writes are lost.
// TESTING
//  1 Run TOP=9,CMP=3, assert i_sysrst=0 for 2 cycles at cnt=6
//    -> cnt=0, pin=0, flags=0, cmp_act=top_act=FFFF.
//  2 Toggle: TOP=9,CMP=3,en=1 -> pin toggles the cycle after cnt==3, 20-clk period;
//    o_oc_flg=1; o_ovf_flg=1 after cnt 9->0.
//  3 PWM: TOP=9,CMP=4 -> pin high 4/10 cycles, rising at cnt 0, falling at cnt 4;
//    CMP=0 -> always 0; CMP=10 -> always 1.
//  4 Shadow: running CMP=3, write CMP=7 at cnt=5 -> no match at 7 this period;
//    next period matches at 7, not 3.
//  5 Priority: cnt=5, i_clr=1 & en=1 -> cnt=0 next, o_ovf_flg unchanged;
//    en=0 at cnt=4 -> cnt, pin frozen.
//  6 Flags: i_flg_clr on match cycle -> o_oc_flg stays 1;
//    i_flg_clr alone -> both flags 0 next cycle.

Source files
------------

// File: rtl/output_compare.sv
// 16-bit timer output-compare channel: free-running counter with double-buffered
// period/compare registers driving a toggle/set/clear/PWM pin and sticky flags.
module output_compare #(
  parameter logic [15:0] CMP_RST = 16'hFFFF,
  parameter logic [15:0] TOP_RST = 16'hFFFF
) (
  input  logic        i_sysclk,
  input  logic        i_sysrst,
  input  logic        i_cnt_en,
  input  logic        i_clr,
  input  logic        i_cmp_wr,
  input  logic [15:0] i_cmp_data,
  input  logic        i_top_wr,
  input  logic [15:0] i_top_data,
  input  logic [1:0]  i_mode,
  input  logic        i_flg_clr,
  output logic        o_oc_pin,
  output logic        o_oc_flg,
  output logic        o_ovf_flg,
  output logic [15:0] o_cnt_data
);

  localparam logic [1:0] MODE_TOGGLE = 2'b00;
  localparam logic [1:0] MODE_SET    = 2'b01;
  localparam logic [1:0] MODE_CLEAR  = 2'b10;
  localparam logic [1:0] MODE_PWM    = 2'b11;

  logic [15:0] cnt_r;
  logic [15:0] cmp_buf_r;
  logic [15:0] top_buf_r;
  logic [15:0] cmp_act_r;
  logic [15:0] top_act_r;
  logic        pin_r;
  logic        oc_flg_r;
  logic        ovf_flg_r;

  logic        run_s;
  logic        wrap_s;
  logic        update_s;
  logic        match_s;
  logic [15:0] cnt_next_s;
  logic [15:0] cmp_next_s;
  logic [15:0] top_next_s;
  logic        pin_next_s;
  logic        oc_flg_next_s;
  logic        ovf_flg_next_s;

  // Event decode: a clear or a disabled cycle is also a safe point to reload the shadows.
  always_comb begin
    run_s    = i_cnt_en & ~i_clr;
    wrap_s   = run_s & (cnt_r == top_act_r);
    update_s = wrap_s | i_clr | ~i_cnt_en;
    match_s  = run_s & (cnt_r == cmp_act_r) & (cmp_act_r <= top_act_r);
  end

  // Counter next value: clear beats wrap beats increment.
  always_comb begin
    cnt_next_s = cnt_r;
    if (i_clr) begin
      cnt_next_s = 16'h0000;
    end else if (wrap_s) begin
      cnt_next_s = 16'h0000;
    end else if (i_cnt_en) begin
      cnt_next_s = cnt_r + 16'h0001;
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Active register reload uses buffer contents from before this edge's writes.
  always_comb begin
    cmp_next_s = cmp_act_r;
    top_next_s = top_act_r;
    if (update_s) begin
      cmp_next_s = cmp_buf_r;
      top_next_s = top_buf_r;
    end else begin
      cmp_next_s = cmp_act_r;
      top_next_s = top_act_r;
    end
  end

  // Pin next value; PWM compares against the values the counter and CMP take at this edge.
  always_comb begin
    pin_next_s = pin_r;
    if (i_cnt_en) begin
      case (i_mode)
        MODE_TOGGLE: begin
          if (match_s) pin_next_s = ~pin_r;
          else         pin_next_s = pin_r;
        end
        MODE_SET: begin
          if (match_s) pin_next_s = 1'b1;
          else         pin_next_s = pin_r;
        end
        MODE_CLEAR: begin
          if (match_s) pin_next_s = 1'b0;
          else         pin_next_s = pin_r;
        end
        MODE_PWM: pin_next_s = (cnt_next_s < cmp_next_s);
        default:  pin_next_s = pin_r;
      endcase
    end else begin
      pin_next_s = pin_r;
    end
  end

  // Sticky flags: a set event in the same cycle as a clear request wins.
  always_comb begin
    oc_flg_next_s  = oc_flg_r;
    ovf_flg_next_s = ovf_flg_r;
    if (match_s) begin
      oc_flg_next_s = 1'b1;
    end else if (i_flg_clr) begin
      oc_flg_next_s = 1'b0;
    end else begin
      oc_flg_next_s = oc_flg_r;
    end
    if (wrap_s) begin
      ovf_flg_next_s = 1'b1;
    end else if (i_flg_clr) begin
      ovf_flg_next_s = 1'b0;
    end else begin
      ovf_flg_next_s = ovf_flg_r;
    end
  end

  // Buffer registers capture host writes; a pending write is discarded by reset.
  always_ff @(posedge i_sysclk) begin
    if (!i_sysrst) begin
      cmp_buf_r <= CMP_RST;
      top_buf_r <= TOP_RST;
    end else begin
      if (i_cmp_wr) cmp_buf_r <= i_cmp_data;
      if (i_top_wr) top_buf_r <= i_top_data;
    end
  end

  // Counter, active registers, pin and flags.
  always_ff @(posedge i_sysclk) begin
    if (!i_sysrst) begin
      cnt_r     <= 16'h0000;
      cmp_act_r <= CMP_RST;
      top_act_r <= TOP_RST;
      pin_r     <= 1'b0;
      oc_flg_r  <= 1'b0;
      ovf_flg_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_next_s;
      cmp_act_r <= cmp_next_s;
      top_act_r <= top_next_s;
      pin_r     <= pin_next_s;
      oc_flg_r  <= oc_flg_next_s;
      ovf_flg_r <= ovf_flg_next_s;
    end
  end

  assign o_oc_pin   = pin_r;
  assign o_oc_flg   = oc_flg_r;
  assign o_ovf_flg  = ovf_flg_r;
  assign o_cnt_data = cnt_r;

endmodule

// File: tb/tb_output_compare.sv
// Directed bench for output_compare: reset, toggle, flags, priority, shadow update, PWM.
module tb_output_compare;

  logic        i_sysclk;
  logic        i_sysrst;
  logic        i_cnt_en;
  logic        i_clr;
  logic        i_cmp_wr;
  logic [15:0] i_cmp_data;
  logic        i_top_wr;
  logic [15:0] i_top_data;
  logic [1:0]  i_mode;
  logic        i_flg_clr;
  logic        o_oc_pin;
  logic        o_oc_flg;
  logic        o_ovf_flg;
  logic [15:0] o_cnt_data;

  int checks_r   = 0;
  int failures_r = 0;
  int high_cnt_s;
  logic [15:0] exp_cnt_s;

  output_compare dut (
    .i_sysclk   (i_sysclk),
    .i_sysrst   (i_sysrst),
    .i_cnt_en   (i_cnt_en),
    .i_clr      (i_clr),
    .i_cmp_wr   (i_cmp_wr),
    .i_cmp_data (i_cmp_data),
    .i_top_wr   (i_top_wr),
    .i_top_data (i_top_data),
    .i_mode     (i_mode),
    .i_flg_clr  (i_flg_clr),
    .o_oc_pin   (o_oc_pin),
    .o_oc_flg   (o_oc_flg),
    .o_ovf_flg  (o_ovf_flg),
    .o_cnt_data (o_cnt_data)
  );

  initial i_sysclk = 1'b0;
  always #5 i_sysclk = ~i_sysclk;

  task automatic tick();
    @(posedge i_sysclk);
    #1;
  endtask

  task automatic chk_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks_r = checks_r + 1;
    if (obs !== exp) begin
      failures_r = failures_r + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    i_sysrst = 1'b0; i_cnt_en = 1'b0; i_clr = 1'b0; i_cmp_wr = 1'b0;
    i_cmp_data = 16'h0000; i_top_wr = 1'b0; i_top_data = 16'h0000;
    i_mode = 2'b00; i_flg_clr = 1'b0;
    tick(); tick();
    i_sysrst = 1'b1;
    chk_eq("rst_cnt", o_cnt_data, 16'd0);
    chk_eq("rst_pin", {15'd0, o_oc_pin}, 16'd0);
    chk_eq("rst_ocflg", {15'd0, o_oc_flg}, 16'd0);
    chk_eq("rst_ovf", {15'd0, o_ovf_flg}, 16'd0);

    // Load TOP=9, CMP=3 while disabled (two edges: write, then reload)
    i_top_wr = 1'b1; i_top_data = 16'd9; i_cmp_wr = 1'b1; i_cmp_data = 16'd3;
    tick();
    i_top_wr = 1'b0; i_cmp_wr = 1'b0;
    tick();

    // Toggle mode
    i_cnt_en = 1'b1;
    repeat (3) tick();
    chk_eq("tog_cnt3", o_cnt_data, 16'd3);
    chk_eq("tog_pin_pre", {15'd0, o_oc_pin}, 16'd0);
    chk_eq("tog_flg_pre", {15'd0, o_oc_flg}, 16'd0);
    tick();
    chk_eq("tog_cnt4", o_cnt_data, 16'd4);
    chk_eq("tog_pin_hi", {15'd0, o_oc_pin}, 16'd1);
    chk_eq("tog_flg", {15'd0, o_oc_flg}, 16'd1);
    repeat (5) tick();
    chk_eq("tog_cnt9", o_cnt_data, 16'd9);
    chk_eq("ovf_pre", {15'd0, o_ovf_flg}, 16'd0);
    tick();
    chk_eq("wrap_cnt0", o_cnt_data, 16'd0);
    chk_eq("ovf_set", {15'd0, o_ovf_flg}, 16'd1);
    repeat (4) tick();
    chk_eq("tog2_cnt4", o_cnt_data, 16'd4);
    chk_eq("tog_pin_lo", {15'd0, o_oc_pin}, 16'd0);

    // Flag clear alone, then flag clear on a match cycle
    i_flg_clr = 1'b1;
    tick();
    i_flg_clr = 1'b0;
    chk_eq("flgclr_oc", {15'd0, o_oc_flg}, 16'd0);
    chk_eq("flgclr_ovf", {15'd0, o_ovf_flg}, 16'd0);
    repeat (8) tick();
    chk_eq("flg_cnt3", o_cnt_data, 16'd3);
    i_flg_clr = 1'b1;
    tick();
    i_flg_clr = 1'b0;
    chk_eq("flg_setwins", {15'd0, o_oc_flg}, 16'd1);
    chk_eq("flg_pin", {15'd0, o_oc_pin}, 16'd1);

    // Priority: clear with enable at cnt=5; freeze at cnt=4
    i_flg_clr = 1'b1;
    tick();
    i_flg_clr = 1'b0;
    chk_eq("pri_cnt5", o_cnt_data, 16'd5);
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    chk_eq("pri_clr_cnt", o_cnt_data, 16'd0);
    chk_eq("pri_clr_ovf", {15'd0, o_ovf_flg}, 16'd0);
    repeat (4) tick();
    chk_eq("pri_cnt4", o_cnt_data, 16'd4);
    chk_eq("pri_pin", {15'd0, o_oc_pin}, 16'd0);
    i_cnt_en = 1'b0;
    repeat (3) tick();
    chk_eq("frz_cnt", o_cnt_data, 16'd4);
    chk_eq("frz_pin", {15'd0, o_oc_pin}, 16'd0);
    chk_eq("frz_flg", {15'd0, o_oc_flg}, 16'd1);

    // Shadow: write CMP=7 at cnt=5, takes effect after wrap
    i_cnt_en = 1'b1;
    tick();
    chk_eq("sh_cnt5", o_cnt_data, 16'd5);
    i_cmp_wr = 1'b1; i_cmp_data = 16'd7; i_flg_clr = 1'b1;
    tick();
    i_cmp_wr = 1'b0; i_flg_clr = 1'b0;
    tick(); tick();
    chk_eq("sh_cnt8", o_cnt_data, 16'd8);
    chk_eq("sh_nomatch7", {15'd0, o_oc_flg}, 16'd0);
    repeat (2) tick();
    repeat (4) tick();
    chk_eq("sh_cnt4", o_cnt_data, 16'd4);
    chk_eq("sh_nomatch3", {15'd0, o_oc_flg}, 16'd0);
    repeat (4) tick();
    chk_eq("sh_cnt8b", o_cnt_data, 16'd8);
    chk_eq("sh_match7", {15'd0, o_oc_flg}, 16'd1);

    // PWM with CMP=4: load while disabled and cleared
    i_cnt_en = 1'b0; i_clr = 1'b1; i_mode = 2'b11;
    i_cmp_wr = 1'b1; i_cmp_data = 16'd4;
    tick();
    i_cmp_wr = 1'b0;
    tick();
    i_clr = 1'b0; i_cnt_en = 1'b1;
    high_cnt_s = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_cnt_s = 16'(i % 10);
      chk_eq("pwm4_cnt", o_cnt_data, exp_cnt_s);
      chk_eq("pwm4_pin", {15'd0, o_oc_pin}, (exp_cnt_s < 16'd4) ? 16'd1 : 16'd0);
      if (i > 10) high_cnt_s = high_cnt_s + int'(o_oc_pin);
    end
    chk_eq("pwm4_duty", 16'(high_cnt_s), 16'd4);

    // PWM CMP=0: constant low from the next period
    i_cmp_wr = 1'b1; i_cmp_data = 16'd0;
    tick();
    i_cmp_wr = 1'b0;
    chk_eq("pwm0_old", {15'd0, o_oc_pin}, 16'd1);
    repeat (9) tick();
    high_cnt_s = 0;
    for (int i = 0; i < 10; i++) begin
      high_cnt_s = high_cnt_s + int'(o_oc_pin);
      tick();
    end
    chk_eq("pwm0_duty", 16'(high_cnt_s), 16'd0);

    // PWM CMP=10 > TOP: constant high from the next period
    i_cmp_wr = 1'b1; i_cmp_data = 16'd10;
    tick();
    i_cmp_wr = 1'b0;
    repeat (9) tick();
    high_cnt_s = 0;
    for (int i = 0; i < 10; i++) begin
      high_cnt_s = high_cnt_s + int'(o_oc_pin);
      tick();
    end
    chk_eq("pwm10_duty", 16'(high_cnt_s), 16'd10);

    // Reset mid-run at cnt=6 with a pending write
    i_mode = 2'b00;
    repeat (6) tick();
    chk_eq("mr_cnt6", o_cnt_data, 16'd6);
    i_sysrst = 1'b0; i_cmp_wr = 1'b1; i_cmp_data = 16'd5;
    tick(); tick();
    i_sysrst = 1'b1; i_cmp_wr = 1'b0;
    chk_eq("mr_cnt", o_cnt_data, 16'd0);
    chk_eq("mr_pin", {15'd0, o_oc_pin}, 16'd0);
    chk_eq("mr_oc", {15'd0, o_oc_flg}, 16'd0);
    chk_eq("mr_ovf", {15'd0, o_ovf_flg}, 16'd0);
    repeat (12) tick();
    chk_eq("mr_top_ffff", o_cnt_data, 16'd12);
    chk_eq("mr_no_match", {15'd0, o_oc_flg}, 16'd0);
    chk_eq("mr_no_ovf", {15'd0, o_ovf_flg}, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
    $finish;
  end

endmodule
